// File: rtl/axi_stream_insert_arbiter.sv
// Packet-level round-robin arbiter sharing one header-insert datapath between NUM_SRC sources.
// A grant covers one header plus the payload up to and including its last beat.
//
//   state | meaning
//   IDLE  | no grant held; searching requesters from rr_ptr upward
//   GRANT | grant_id owns the datapath until header and last beat are both accepted
module axi_stream_insert_arbiter #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_SRC      = 4,
  parameter int SRC_ID_WD    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_header_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
  output logic [NUM_SRC-1:0]                s_ready_insert,
  input  logic [NUM_SRC-1:0]                s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
  input  logic [NUM_SRC-1:0]                s_last_in,
  output logic [NUM_SRC-1:0]                s_ready_in,
  output logic                              m_valid_insert,
  output logic [DATA_WD-1:0]                m_header_insert,
  output logic [DATA_BYTE_WD-1:0]           m_keep_insert,
  input  logic                              m_ready_insert,
  output logic                              m_valid_in,
  output logic [DATA_WD-1:0]                m_data_in,
  output logic [DATA_BYTE_WD-1:0]           m_keep_in,
  output logic                              m_last_in,
  input  logic                              m_ready_in,
  output logic [SRC_ID_WD-1:0]              grant_id,
  output logic                              busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_nxt;
  logic [SRC_ID_WD-1:0]  grant_nxt, rr_ptr, rr_nxt, pick_id, pick_lo, pick_hi;
  logic                  hdr_done, hdr_done_nxt, last_done, last_done_nxt;
  logic                  hdr_hs, last_hs, found_hi;

  // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    pick_lo  = '0;
    pick_hi  = '0;
    found_hi = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (s_valid_insert[i]) begin
        pick_lo = SRC_ID_WD'(i);
        if (i >= int'(rr_ptr)) begin
          pick_hi  = SRC_ID_WD'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick_id = found_hi ? pick_hi : pick_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_id  <= '0;
      rr_ptr    <= '0;
      hdr_done  <= 1'b0;
      last_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      rr_ptr    <= rr_nxt;
      hdr_done  <= hdr_done_nxt;
      last_done <= last_done_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant_id;
    rr_nxt          = rr_ptr;
    hdr_done_nxt    = hdr_done;
    last_done_nxt   = last_done;
    m_valid_insert  = 1'b0;
    m_header_insert = '0;
    m_keep_insert   = '0;
    m_valid_in      = 1'b0;
    m_data_in       = '0;
    m_keep_in       = '0;
    m_last_in       = 1'b0;
    s_ready_insert  = '0;
    s_ready_in      = '0;
    hdr_hs          = 1'b0;
    last_hs         = 1'b0;
    case (state)
      IDLE: begin
        if (|s_valid_insert) begin
          state_nxt = GRANT;
          grant_nxt = pick_id;
        end
      end
      GRANT: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (i == int'(grant_id)) begin
            m_valid_insert    = s_valid_insert[i] & ~hdr_done;
            s_ready_insert[i] = m_ready_insert & ~hdr_done;
            if (m_valid_insert) begin
              m_header_insert = s_header_insert[i*DATA_WD +: DATA_WD];
              m_keep_insert   = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            end
            // Payload is closed after the last beat so the next packet's beats wait for a new grant.
            m_valid_in    = s_valid_in[i] & ~last_done;
            s_ready_in[i] = m_ready_in & ~last_done;
            if (m_valid_in) begin
              m_data_in = s_data_in[i*DATA_WD +: DATA_WD];
              m_keep_in = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
              m_last_in = s_last_in[i];
            end
          end
        end
        hdr_hs  = m_valid_insert & m_ready_insert;
        last_hs = m_valid_in & m_ready_in & m_last_in;
        if ((hdr_done | hdr_hs) && (last_done | last_hs)) begin
          state_nxt     = IDLE;
          rr_nxt        = (grant_id == SRC_ID_WD'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
          hdr_done_nxt  = 1'b0;
          last_done_nxt = 1'b0;
        end else begin
          hdr_done_nxt  = hdr_done | hdr_hs;
          last_done_nxt = last_done | last_hs;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == GRANT);

endmodule
